// File: rtl/dram_tile_reader_pkg.sv
// tile_reader_pkg: FSM encoding and length default shared by the tile reader and tile writer.
package tile_reader_pkg;
    localparam int DEF_LEN_WIDTH = 6;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} tile_state_e;
endpackage

// File: rtl/dram_tile_reader_if.sv
// dram_tile_reader_if: tile request, DRAM read port and output stream of the tile reader.
interface dram_tile_reader_if import tile_reader_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [LEN_WIDTH-1:0]  req_width;
    logic [LEN_WIDTH-1:0]  req_rows;
    logic [ADDR_WIDTH-1:0] req_stride;
    logic                  dram_en_rd;
    logic [ADDR_WIDTH-1:0] dram_addr_rd;
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] dram_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  done;
    modport master (
        output req_ready, dram_en_rd, dram_addr_rd, out_valid, out_data, out_last, done,
        input  req_valid, req_base, req_width, req_rows, req_stride, dram_valid, dram_data, out_ready
    );
    modport slave (
        input  req_ready, dram_en_rd, dram_addr_rd, out_valid, out_data, out_last, done,
        output req_valid, req_base, req_width, req_rows, req_stride, dram_valid, dram_data, out_ready
    );
endinterface

// File: rtl/dram_tile_reader_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; storage is registered so head never depends on push.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    always_ff @(posedge clk)
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            assert (!(push && full && !pop));
            if (push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    assign full  = r_cnt == (AW+1)'(DEPTH);
    assign empty = r_cnt == '0;
    assign count = r_cnt;
    assign head  = r_mem[r_rd];
endmodule

// File: rtl/dram_tile_reader.sv
// dram_tile_reader: walks a rectangular tile row by row, issuing credit-limited single-word
// DRAM reads and streaming the returned words downstream through a small FIFO.
module dram_tile_reader import tile_reader_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                srst,
    dram_tile_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    tile_state_e             r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_stride, r_row_ptr;
    logic [LEN_WIDTH-1:0]    r_width, r_rows, r_col, r_row;
    logic [2*LEN_WIDTH-1:0]  r_total, r_ret;
    logic [CW-1:0]           r_inflight;
    logic                    r_done;
    logic                    w_accept, w_zero, w_credit, w_issue, w_col_end, w_last_issue;
    logic                    w_pop, w_last_tag, w_full, w_empty;
    logic [FW-1:0]           w_count;
    logic [DATA_WIDTH:0]     w_head;
    assign w_accept     = bus.req_valid && bus.req_ready;
    assign w_zero       = bus.req_width == '0 || bus.req_rows == '0;
    // Words issued but not yet popped can never exceed the FIFO, so a return always has room.
    assign w_credit     = (int'(w_count) + int'(r_inflight)) < FIFO_DEPTH;
    assign w_issue      = r_state == ISSUE && w_credit && !srst;
    assign w_col_end    = r_col == r_width - 1'b1;
    assign w_last_issue = w_issue && w_col_end && r_row == r_rows - 1'b1;
    assign w_pop        = bus.out_valid && bus.out_ready;
    assign w_last_tag   = r_ret + 1'b1 == r_total;
    assign bus.req_ready    = r_state == IDLE && !r_done;
    assign bus.dram_en_rd   = w_issue;
    assign bus.dram_addr_rd = r_row_ptr + ADDR_WIDTH'(r_col);
    assign bus.out_valid    = !w_empty;
    assign {bus.out_last, bus.out_data} = w_head;
    assign bus.done         = r_done;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept && !w_zero ? ISSUE : IDLE;
            ISSUE:   w_next = w_last_issue ? DRAIN : ISSUE;
            DRAIN:   w_next = w_pop && bus.out_last && r_inflight == '0 ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) r_state <= srst ? IDLE : w_next;
    always_ff @(posedge clk)
        if (srst) begin
            r_stride   <= '0;
            r_row_ptr  <= '0;
            r_width    <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_total    <= '0;
            r_ret      <= '0;
            r_inflight <= '0;
            r_done     <= 1'b0;
        end else begin
            assert (int'(w_count) + int'(r_inflight) <= FIFO_DEPTH && !(w_full && bus.dram_valid && !w_pop));
            r_done     <= (w_accept && w_zero) || (r_state == DRAIN && w_next == IDLE);
            r_inflight <= r_inflight + CW'(w_issue) - CW'(bus.dram_valid);
            if (w_accept) begin
                r_width   <= bus.req_width;
                r_rows    <= bus.req_rows;
                r_stride  <= bus.req_stride;
                r_row_ptr <= bus.req_base;
                r_col     <= '0;
                r_row     <= '0;
                r_ret     <= '0;
                r_total   <= (2*LEN_WIDTH)'(bus.req_width) * (2*LEN_WIDTH)'(bus.req_rows);
            end else begin
                if (bus.dram_valid) r_ret <= r_ret + 1'b1;
                if (w_issue) begin
                    r_col <= w_col_end ? '0 : r_col + 1'b1;
                    if (w_col_end) begin
                        r_row_ptr <= r_row_ptr + r_stride;
                        r_row     <= r_row + 1'b1;
                    end
                end
            end
        end
    sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (bus.dram_valid),
        .pop   (w_pop),
        .din   ({w_last_tag, bus.dram_data}),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (w_head)
    );
endmodule

// File: tb/tb_dram_tile_reader.sv
// tb_dram_tile_reader: directed and randomized tiles checked against an address-list model
// of the tile walk; the DRAM is a one-cycle-latency model returning 0x1000 + address.
`timescale 1ns/1ps
module tb_dram_tile_reader;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;
    dram_tile_reader_if b();
    dram_tile_reader #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .srst(srst), .bus(b));
    always @(posedge clk) begin
        b.dram_valid <= b.dram_en_rd;
        b.dram_data  <= b.dram_en_rd ? 32'h1000 + 32'(b.dram_addr_rd) : 32'h0;
    end
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int acc_cyc, first_iss, first_ov, last_hs, done_cyc, done_cnt, n_iss, n_pop, rr_after_done;
    logic        prev_hold;
    logic [32:0] prev_head;
    logic [17:0] exp_addr[$];
    logic [31:0] exp_data[$];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input logic rdy, input logic rv);
        logic [17:0] ea;
        logic [31:0] ed;
        @(negedge clk);
        b.out_ready = rdy;
        b.req_valid = rv;
        #1;
        cyc++;
        if (prev_hold) begin
            chk("hold_valid", 64'(b.out_valid), 64'd1);
            chk("hold_head", 64'({b.out_last, b.out_data}), 64'(prev_head));
        end
        prev_hold = b.out_valid && !rdy;
        prev_head = {b.out_last, b.out_data};
        if (b.dram_en_rd) begin
            n_iss++;
            if (first_iss < 0) first_iss = cyc;
            ea = exp_addr.size() > 0 ? exp_addr.pop_front() : 'x;
            chk("rd_addr", 64'(b.dram_addr_rd), 64'(ea));
        end
        if (b.out_valid && first_ov < 0) first_ov = cyc;
        if (b.out_valid && rdy) begin
            n_pop++;
            ed = exp_data.size() > 0 ? exp_data.pop_front() : 'x;
            chk("data", 64'(b.out_data), 64'(ed));
            chk("last", 64'(b.out_last), 64'(exp_data.size() == 0));
            if (b.out_last) last_hs = cyc;
        end
        if (done_cnt > 0 && cyc == done_cyc + 1) rr_after_done = int'(b.req_ready);
        if (b.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("ready_at_done", 64'(b.req_ready), 64'd0);
        end
        if (n_iss - n_pop > DEPTH) chk("credit", 64'(n_iss - n_pop), 64'(DEPTH));
    endtask
    task automatic prepare(input logic [17:0] base, input logic [5:0] w, input logic [5:0] r,
                           input logic [17:0] st);
        exp_addr.delete();
        exp_data.delete();
        for (int y = 0; y < int'(r); y++)
            for (int x = 0; x < int'(w); x++) begin
                logic [17:0] a;
                a = 18'((int'(base) + y * int'(st) + x) % (1 << 18));
                exp_addr.push_back(a);
                exp_data.push_back(32'h1000 + 32'(a));
            end
        b.req_base = base;
        b.req_width = w;
        b.req_rows = r;
        b.req_stride = st;
        first_iss = -1; first_ov = -1; last_hs = -1; done_cyc = -1;
        done_cnt = 0; n_iss = 0; n_pop = 0; rr_after_done = 0; prev_hold = 1'b0;
    endtask
    // mode 0: always ready, 1: 50% random ready, 2: ready held low for 10 cycles after acceptance
    task automatic run_tile(input logic [17:0] base, input logic [5:0] w, input logic [5:0] r,
                            input logic [17:0] st, input int mode);
        int   total;
        logic rdy;
        total = int'(w) * int'(r);
        prepare(base, w, r, st);
        tick(1'b1, 1'b1);
        chk("req_ready", 64'(b.req_ready), 64'd1);
        acc_cyc = cyc;
        for (int k = 0; k < 400 && done_cnt == 0; k++) begin
            rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(cyc + 1 > acc_cyc + 10);
            tick(rdy, 1'b0);
            if (mode == 2 && cyc == acc_cyc + 10) chk("bp_issues", 64'(n_iss), 64'(DEPTH));
        end
        tick(1'b1, 1'b0);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("issues", 64'(n_iss), 64'(total));
        chk("words", 64'(n_pop), 64'(total));
        chk("words_left", 64'(exp_data.size()), 64'd0);
        chk("req_ready_back", 64'(rr_after_done), 64'd1);
        if (total == 0) begin
            chk("zero_done_lat", 64'(done_cyc - acc_cyc), 64'd1);
            chk("zero_no_out", 64'(first_ov), 64'(-1));
        end else begin
            chk("first_rd_lat", 64'(first_iss - acc_cyc), 64'd1);
            chk("first_out_lat", 64'(first_ov - acc_cyc), 64'd3);
            chk("done_lat", 64'(done_cyc - last_hs), 64'd1);
        end
    endtask
    initial begin
        b.req_valid = 1'b0;
        b.out_ready = 1'b0;
        prepare(18'h0, 6'd0, 6'd0, 18'h0);
        repeat (3) begin
            tick(1'b0, 1'b0);
            chk("rst_out_valid", 64'(b.out_valid), 64'd0);
            chk("rst_en_rd", 64'(b.dram_en_rd), 64'd0);
            chk("rst_done", 64'(b.done), 64'd0);
            chk("rst_head", 64'({b.out_last, b.out_data}), 64'd0);
        end
        srst = 1'b0;
        tick(1'b0, 1'b0);
        chk("ready_after_rst", 64'(b.req_ready), 64'd1);
        run_tile(18'h0, 6'd4, 6'd2, 18'd32, 0);
        run_tile(18'($urandom), 6'd8, 6'd1, 18'd32, 2);
        run_tile(18'($urandom), 6'd5, 6'd3, 18'd32, 1);
        run_tile(18'($urandom), 6'd0, 6'd3, 18'd32, 1);
        run_tile(18'($urandom), 6'd3, 6'd0, 18'd32, 1);
        run_tile(18'h3FFFE, 6'd4, 6'd1, 18'd32, 0);
        repeat (4)
            run_tile(18'($urandom), 6'($urandom_range(1, 7)), 6'($urandom_range(1, 4)),
                     18'($urandom_range(0, 64)), 1);
        // Reset while reads are outstanding and the FIFO is partly full.
        prepare(18'h100, 6'd8, 6'd2, 18'd32);
        tick(1'b1, 1'b1);
        repeat (4) tick(1'b0, 1'b0);
        srst = 1'b1;
        prev_hold = 1'b0;
        tick(1'b0, 1'b0);
        chk("midrst_out_valid", 64'(b.out_valid), 64'd0);
        chk("midrst_en_rd", 64'(b.dram_en_rd), 64'd0);
        chk("midrst_done", 64'(b.done), 64'd0);
        chk("midrst_head", 64'({b.out_last, b.out_data}), 64'd0);
        tick(1'b0, 1'b0);
        srst = 1'b0;
        tick(1'b0, 1'b0);
        chk("midrst_ready", 64'(b.req_ready), 64'd1);
        run_tile(18'h200, 6'd6, 6'd2, 18'd32, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
